// File: rtl/spw_router_pkg.sv
// Shared types and character helpers for the SpaceWire router switching core.
package spw_router_pkg;

  localparam int CHAR_W = 9;

  localparam logic [CHAR_W-1:0] EOP_CHAR = 9'h100;
  localparam logic [CHAR_W-1:0] EEP_CHAR = 9'h101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_FWD,
    ST_DISCARD
  } in_state_e;

  function automatic logic is_eop_eep(input logic [CHAR_W-1:0] c);
    return (c == EOP_CHAR) || (c == EEP_CHAR);
  endfunction

endpackage

// File: rtl/spw_router_xbar_rr_arbiter.sv
// Per-output round-robin arbiter: registered one-hot grant held until release.
// Latency: grant registered on the edge after req; backpressure: none, requesters wait.
module rr_arbiter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         rel,
  output logic [N-1:0] grant,
  output logic [N-1:0] grant_nxt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  grant_q, grant_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] sel;
  logic          found;

  always_comb begin
    grant_d = grant_q;
    ptr_d   = ptr_q;
    found   = 1'b0;
    sel     = '0;
    if (|grant_q) begin
      if (rel) begin
        grant_d = '0;
      end
    end else begin
      // scan from the pointer, wrapping, and take the first requester
      for (int k = 0; k < N; k++) begin
        sel = PW'((int'(ptr_q) + k) % N);
        if (!found && req[sel]) begin
          found        = 1'b1;
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          ptr_d        = (sel == PW'(N - 1)) ? '0 : sel + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant     = grant_q;
  assign grant_nxt = grant_d;

endmodule

// File: rtl/spw_router_xbar.sv
// Packet switch core: header byte selects the output, output locked to one input until EOP/EEP.
// Latency: header to first payload 2 cycles, payload 0-cycle pass-through; backpressure: rx_ready follows the granted tx_ready.
module spw_router_xbar #(
  parameter int COUNT  = 8,
  parameter int CHAR_W = 9,
  parameter int DROP_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [COUNT*CHAR_W-1:0] rx_char,
  input  logic [COUNT-1:0]        rx_valid,
  output logic [COUNT-1:0]        rx_ready,
  output logic [COUNT*CHAR_W-1:0] tx_char,
  output logic [COUNT-1:0]        tx_valid,
  input  logic [COUNT-1:0]        tx_ready,
  output logic [COUNT*DROP_W-1:0] drop_cnt
);
  import spw_router_pkg::*;

  localparam int DW = (COUNT > 1) ? $clog2(COUNT) : 1;

  logic [CHAR_W-1:0] rx_ch       [COUNT];
  in_state_e         state_q     [COUNT];
  in_state_e         state_d     [COUNT];
  logic [DW-1:0]     dest_q      [COUNT];
  logic [DW-1:0]     dest_d      [COUNT];
  logic [DROP_W-1:0] drop_q      [COUNT];
  logic [DROP_W-1:0] drop_d      [COUNT];
  logic [COUNT-1:0]  req_m       [COUNT];
  logic [COUNT-1:0]  grant_m     [COUNT];
  logic [COUNT-1:0]  grant_nxt_m [COUNT];
  logic [CHAR_W-1:0] tx_c        [COUNT];
  logic [COUNT-1:0]  rx_rdy;
  logic [COUNT-1:0]  tx_v;
  logic [COUNT-1:0]  rel;

  always_comb begin
    for (int i = 0; i < COUNT; i++) begin
      rx_ch[i] = rx_char[i*CHAR_W +: CHAR_W];
    end
  end

  // req_m[j][i]: input i waits for output j
  always_comb begin
    for (int j = 0; j < COUNT; j++) begin
      req_m[j] = '0;
    end
    for (int i = 0; i < COUNT; i++) begin
      if (state_q[i] == ST_REQ) begin
        req_m[dest_q[i]][i] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < COUNT; i++) begin
      state_d[i] = state_q[i];
      dest_d[i]  = dest_q[i];
      drop_d[i]  = drop_q[i];
      rx_rdy[i]  = 1'b0;
      case (state_q[i])
        ST_IDLE: begin
          rx_rdy[i] = 1'b1;
          // a control character here is an empty packet and is silently eaten
          if (rx_valid[i] && !rx_ch[i][CHAR_W-1]) begin
            if (int'(rx_ch[i][7:0]) < COUNT) begin
              dest_d[i]  = rx_ch[i][DW-1:0];
              state_d[i] = ST_REQ;
            end else begin
              state_d[i] = ST_DISCARD;
              if (drop_q[i] != '1) begin
                drop_d[i] = drop_q[i] + DROP_W'(1);
              end
            end
          end
        end
        ST_REQ: begin
          if (grant_nxt_m[dest_q[i]][i]) begin
            state_d[i] = ST_FWD;
          end
        end
        ST_FWD: begin
          rx_rdy[i] = tx_ready[dest_q[i]];
          if (rx_valid[i] && tx_ready[dest_q[i]] && is_eop_eep(rx_ch[i])) begin
            state_d[i] = ST_IDLE;
          end
        end
        ST_DISCARD: begin
          rx_rdy[i] = 1'b1;
          if (rx_valid[i] && is_eop_eep(rx_ch[i])) begin
            state_d[i] = ST_IDLE;
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < COUNT; i++) begin
        state_q[i] <= ST_IDLE;
        dest_q[i]  <= '0;
        drop_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < COUNT; i++) begin
        state_q[i] <= state_d[i];
        dest_q[i]  <= dest_d[i];
        drop_q[i]  <= drop_d[i];
      end
    end
  end

  // AND-OR mux per output; the one-hot grant selects the owning input
  always_comb begin
    for (int j = 0; j < COUNT; j++) begin
      tx_c[j] = '0;
      tx_v[j] = 1'b0;
      for (int i = 0; i < COUNT; i++) begin
        tx_c[j] = tx_c[j] | ({CHAR_W{grant_m[j][i]}} & rx_ch[i]);
        tx_v[j] = tx_v[j] | (grant_m[j][i] & rx_valid[i]);
      end
      rel[j] = tx_v[j] & tx_ready[j] & is_eop_eep(tx_c[j]);
    end
  end

  assign rx_ready = rx_rdy & {COUNT{~rst}};
  assign tx_valid = tx_v & {COUNT{~rst}};

  for (genvar j = 0; j < COUNT; j++) begin : g_port
    rr_arbiter #(
      .N(COUNT)
    ) u_arb (
      .clk      (clk),
      .rst      (rst),
      .req      (req_m[j]),
      .rel      (rel[j]),
      .grant    (grant_m[j]),
      .grant_nxt(grant_nxt_m[j])
    );

    assign tx_char[j*CHAR_W +: CHAR_W]  = tx_c[j];
    assign drop_cnt[j*DROP_W +: DROP_W] = drop_q[j];
  end

endmodule

// File: tb/tb_spw_router_xbar.sv
// Directed bench for spw_router_xbar: routing, arbitration order, discard, backpressure, reset.
module tb_spw_router_xbar;

  localparam int COUNT = 8;
  localparam int CW    = 9;
  localparam int DW    = 8;
  localparam logic [CW-1:0] EOP = 9'h100;
  localparam logic [CW-1:0] EEP = 9'h101;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [COUNT*CW-1:0]   rx_char;
  logic [COUNT-1:0]      rx_valid;
  logic [COUNT-1:0]      rx_ready;
  logic [COUNT*CW-1:0]   tx_char;
  logic [COUNT-1:0]      tx_valid;
  logic [COUNT-1:0]      tx_ready;
  logic [COUNT*DW-1:0]   drop_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spw_router_xbar #(
    .COUNT (COUNT),
    .CHAR_W(CW),
    .DROP_W(DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_char (rx_char),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .tx_char (tx_char),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .drop_cnt(drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic drv(input int i, input logic v, input logic [CW-1:0] c);
    rx_valid[i]        = v;
    rx_char[i*CW +: CW] = c;
  endtask

  function automatic logic [CW-1:0] txc(input int j);
    return tx_char[j*CW +: CW];
  endfunction

  function automatic logic [DW-1:0] dc(input int i);
    return drop_cnt[i*DW +: DW];
  endfunction

  initial begin
    rst      = 1'b1;
    rx_valid = '0;
    rx_char  = '0;
    tx_ready = '1;

    // reset state
    tick; settle;
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_drop_lo", drop_cnt[31:0], 0);
    chk("rst_drop_hi", drop_cnt[63:32], 0);
    tick; rst = 1'b0; settle;
    chk("idle_rx_ready", rx_ready, 8'hFF);
    chk("idle_tx_valid", tx_valid, 0);

    // 1: in0 -> out2, 2-cycle header-to-payload
    drv(0, 1, 9'h002); settle;
    chk("t1_hdr_rdy", rx_ready[0], 1);
    tick; drv(0, 1, 9'h0A5); settle;
    chk("t1_req_rdy", rx_ready[0], 0);
    chk("t1_req_txv", tx_valid, 0);
    tick; settle;
    chk("t1_a5_txv", tx_valid, 8'h04);
    chk("t1_a5", txc(2), 9'h0A5);
    chk("t1_a5_rdy", rx_ready[0], 1);
    chk("t1_out3_char", txc(3), 0);
    tick; drv(0, 1, 9'h05A); settle;
    chk("t1_5a", txc(2), 9'h05A);
    tick; drv(0, 1, EOP); settle;
    chk("t1_eop", txc(2), 9'h100);
    chk("t1_eop_txv", tx_valid, 8'h04);
    tick; drv(0, 0, 9'h000); settle;
    chk("t1_done_txv", tx_valid, 0);
    chk("t1_done_rdy", rx_ready[0], 1);

    // 2: in1 and in3 contend for out4, pointer at 0
    drv(1, 1, 9'h004); drv(3, 1, 9'h004); settle;
    tick; drv(1, 1, 9'h011); drv(3, 1, 9'h033); settle;
    chk("t2_req_rdy", {rx_ready[3], rx_ready[1]}, 2'b00);
    tick; settle;
    chk("t2_first", txc(4), 9'h011);
    chk("t2_first_rdy", {rx_ready[3], rx_ready[1]}, 2'b01);
    tick; drv(1, 1, EOP); settle;
    chk("t2_first_eop", txc(4), 9'h100);
    tick; drv(1, 0, 9'h000); settle;
    chk("t2_gap", tx_valid, 0);
    tick; settle;
    chk("t2_second", txc(4), 9'h033);
    chk("t2_second_txv", tx_valid, 8'h10);
    tick; drv(3, 1, EOP); settle;
    chk("t2_second_eop", txc(4), 9'h100);
    tick; drv(3, 0, 9'h000); drv(0, 1, 9'h004); drv(1, 1, 9'h004); settle;
    tick; drv(0, 1, 9'h0C0); drv(1, 1, 9'h0C1); settle;
    tick; settle;
    chk("t2_third", txc(4), 9'h0C0);
    chk("t2_third_rdy", {rx_ready[1], rx_ready[0]}, 2'b01);
    tick; drv(0, 1, EOP); settle;
    tick; drv(0, 0, 9'h000); settle;
    chk("t2_gap2", tx_valid, 0);
    tick; settle;
    chk("t2_fourth", txc(4), 9'h0C1);
    tick; drv(1, 1, EOP); settle;
    tick; drv(1, 0, 9'h000); settle;
    chk("t2_done_txv", tx_valid, 0);

    // 3: out-of-range header discarded, counter saturates
    drv(5, 1, 9'h009); settle;
    tick; drv(5, 1, 9'h011); settle;
    chk("t3_disc_rdy", rx_ready[5], 1);
    chk("t3_disc_txv", tx_valid, 0);
    chk("t3_cnt1", dc(5), 1);
    tick; drv(5, 1, 9'h022); settle;
    chk("t3_disc_rdy2", rx_ready[5], 1);
    tick; drv(5, 1, EEP); settle;
    chk("t3_eep_txv", tx_valid, 0);
    tick; drv(5, 0, 9'h000); settle;
    chk("t3_cnt1_after", dc(5), 1);
    chk("t3_idle_rdy", rx_ready[5], 1);
    for (int n = 0; n < 253; n++) begin
      drv(5, 1, n[0] ? 9'h0FF : 9'h008);
      tick; drv(5, 1, EEP);
      tick;
    end
    drv(5, 0, 9'h000); settle;
    chk("t3_cnt254", dc(5), 8'hFE);
    for (int n = 0; n < 46; n++) begin
      drv(5, 1, 9'h008);
      tick; drv(5, 1, EEP);
      tick;
    end
    drv(5, 0, 9'h000); settle;
    chk("t3_cnt_sat", dc(5), 8'hFF);
    chk("t3_cnt_other", dc(4), 0);
    chk("t3_end_txv", tx_valid, 0);

    // 4: out6 backpressure on in2
    drv(2, 1, 9'h006); settle;
    tick; drv(2, 1, 9'h0D1); settle;
    tick; settle;
    chk("t4_d1", txc(6), 9'h0D1);
    chk("t4_d1_rdy", rx_ready[2], 1);
    tick; drv(2, 1, 9'h0D2); tx_ready[6] = 1'b0; settle;
    chk("t4_stall1_rdy", rx_ready[2], 0);
    chk("t4_stall1_char", txc(6), 9'h0D2);
    chk("t4_stall1_txv", tx_valid, 8'h40);
    tick; settle;
    chk("t4_stall2_rdy", rx_ready[2], 0);
    tick; tx_ready[6] = 1'b1; settle;
    chk("t4_resume_rdy", rx_ready[2], 1);
    chk("t4_resume_char", txc(6), 9'h0D2);
    tick; drv(2, 1, 9'h0D3); settle;
    chk("t4_d3", txc(6), 9'h0D3);
    tick; drv(2, 1, EOP); tx_ready[6] = 1'b0; settle;
    chk("t4_eop_stall_rdy", rx_ready[2], 0);
    tick; tx_ready[6] = 1'b1; settle;
    chk("t4_eop_held", txc(6), 9'h100);
    chk("t4_eop_held_txv", tx_valid, 8'h40);
    tick; drv(2, 0, 9'h000); settle;
    chk("t4_done_txv", tx_valid, 0);
    chk("t4_done_rdy", rx_ready[2], 1);

    // 5: reset in the middle of a forwarded packet
    drv(0, 1, 9'h001); settle;
    tick; drv(0, 1, 9'h0E1); settle;
    tick; settle;
    chk("t5_fwd", txc(1), 9'h0E1);
    chk("t5_fwd_txv", tx_valid, 8'h02);
    rst = 1'b1; settle;
    chk("t5_rst_txv_now", tx_valid, 0);
    tick; settle;
    chk("t5_rst_txv", tx_valid, 0);
    chk("t5_rst_rdy", rx_ready, 0);
    chk("t5_rst_drop", dc(5), 0);
    tick; rst = 1'b0; drv(0, 0, 9'h000); settle;
    chk("t5_post_rdy", rx_ready, 8'hFF);
    chk("t5_post_txv", tx_valid, 0);
    drv(1, 1, 9'h004); drv(3, 1, 9'h004); settle;
    tick; drv(1, 1, 9'h021); drv(3, 1, 9'h023); settle;
    tick; settle;
    chk("t5_ptr_first", txc(4), 9'h021);
    tick; drv(1, 1, EOP); settle;
    tick; drv(1, 0, 9'h000); settle;
    tick; settle;
    chk("t5_ptr_second", txc(4), 9'h023);
    tick; drv(3, 1, EOP); settle;
    tick; drv(3, 0, 9'h000); drv(0, 1, 9'h001); settle;
    tick; drv(0, 1, 9'h0E2); settle;
    tick; settle;
    chk("t5_new_pkt", txc(1), 9'h0E2);
    chk("t5_new_txv", tx_valid, 8'h02);
    tick; drv(0, 1, EOP); settle;
    tick; drv(0, 0, 9'h000); settle;
    chk("t5_new_done", tx_valid, 0);

    // 6: bare EOP dropped silently, then in7 -> out0
    drv(7, 1, EOP); settle;
    chk("t6_bare_rdy", rx_ready[7], 1);
    chk("t6_bare_txv", tx_valid, 0);
    tick; drv(7, 1, 9'h000); settle;
    chk("t6_hdr_rdy", rx_ready[7], 1);
    tick; drv(7, 1, 9'h033); settle;
    chk("t6_req_rdy", rx_ready[7], 0);
    tick; settle;
    chk("t6_33", txc(0), 9'h033);
    chk("t6_33_txv", tx_valid, 8'h01);
    tick; drv(7, 1, EOP); settle;
    chk("t6_eop", txc(0), 9'h100);
    tick; drv(7, 0, 9'h000); settle;
    chk("t6_done_txv", tx_valid, 0);
    chk("t6_drop7", dc(7), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
